// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its serial receiver:
// stream direction codes and the receiver FSM encoding.
package usr_pkg;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } deser_state_t;

endpackage

// File: rtl/usr_deser_out.sv
// Output holding register for a stream sink: valid/ready handshake with a
// sticky overrun flag raised when a completed word arrives while dout is still held.
module usr_deser_out #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             perr,
  input  logic             dout_rdy,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             overrun,
  output logic             par_err
);

  // A new word may load if the slot is empty or being consumed on this edge.
  logic accept;
  assign accept = load && (!dout_vld || dout_rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      overrun  <= 1'b0;
      par_err  <= 1'b0;
    end else if (clr) begin
      dout_vld <= 1'b0;
      overrun  <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      if (accept) begin
        dout     <= din;
        par_err  <= perr;
        dout_vld <= 1'b1;
      end else if (dout_vld && dout_rdy) begin
        dout_vld <= 1'b0;
      end
      if (load && !accept)
        overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/usr_deser.sv
// Serial-to-parallel receiver for the universal shift register link.
// Define USR_DESER_PARITY_EN to expect a trailing even-parity bit per frame.
module usr_deser
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_vld,
  input  logic             dir,
  input  logic             clr,
  input  logic             dout_rdy,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  output logic             par_err
);

`ifdef USR_DESER_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif

  deser_state_t     state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic             dir_lat;
  logic             eff_dir;
  logic             take;
  logic             frame_end;
  logic [WIDTH-1:0] word;
  logic             perr;

  // The first bit of a word uses the live dir; later bits use the latched copy.
  assign eff_dir   = (state == IDLE) ? dir : dir_lat;
  assign take      = sin_vld && !clr;
  assign frame_end = take && (bit_cnt == CNT_W'(LAST));

  always_comb begin
    sreg_nxt = {sreg[WIDTH-2:0], sin};
    if (eff_dir == DIR_LSB_FIRST)
      sreg_nxt = {sin, sreg[WIDTH-1:1]};
  end

`ifdef USR_DESER_PARITY_EN
  // The final sample is the parity bit; the data word is already complete in sreg.
  assign word = sreg;
  assign perr = (^sreg) ^ sin;
`else
  assign word = sreg_nxt;
  assign perr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      dir_lat <= DIR_MSB_FIRST;
    end else if (clr) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (take) begin
      if (frame_end) begin
        state   <= IDLE;
        sreg    <= '0;
        bit_cnt <= '0;
      end else begin
        state   <= SHIFT;
        sreg    <= sreg_nxt;
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (state == IDLE)
          dir_lat <= dir;
      end
    end
  end

  usr_deser_out #(
    .WIDTH(WIDTH)
  ) u_out (
    .clk      (clk),
    .rst_n    (rst),
    .clr      (clr),
    .load     (frame_end),
    .din      (word),
    .perr     (perr),
    .dout_rdy (dout_rdy),
    .dout     (dout),
    .dout_vld (dout_vld),
    .overrun  (overrun),
    .par_err  (par_err)
  );

endmodule

// File: tb/tb_usr_deser.sv
// Scoreboard bench for usr_deser: expected words are queued as frames are sent
// and popped when the receiver presents them.
module tb_usr_deser;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
`ifdef USR_DESER_PARITY_EN
  localparam int  FRAME = WIDTH + 1;
  localparam bit  PAR   = 1'b1;
`else
  localparam int  FRAME = WIDTH;
  localparam bit  PAR   = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             sin = 1'b0;
  logic             sin_vld = 1'b0;
  logic             dir = 1'b0;
  logic             clr = 1'b0;
  logic             dout_rdy = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;
  logic             par_err;

  int               tests_run = 0;
  int               tests_failed = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  usr_deser #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_vld(sin_vld), .dir(dir), .clr(clr),
    .dout_rdy(dout_rdy), .dout(dout), .dout_vld(dout_vld), .bit_cnt(bit_cnt),
    .overrun(overrun), .par_err(par_err)
  );

  // bits[0] is sent first; MSB-first lands it at word[3], LSB-first at word[0].
  function automatic logic [3:0] expect_word(input logic [0:3] bits, input logic d);
    logic [3:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      if (d == 1'b0) w[3-i] = bits[i];
      else           w[i]   = bits[i];
    end
    return w;
  endfunction

  // Called at a negedge; one rising edge samples the bit, returns at the next negedge.
  task automatic bit_in(input logic b, input logic d);
    sin = b; dir = d; sin_vld = 1'b1;
    @(negedge clk);
    sin_vld = 1'b0;
  endtask

  task automatic send_word(input logic [0:3] bits, input logic d);
    for (int i = 0; i < 4; i++) bit_in(bits[i], d);
`ifdef USR_DESER_PARITY_EN
    bit_in(^bits, d);
`endif
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    @(negedge clk);
    tests_run++;
    if ({dout, dout_vld, bit_cnt, overrun, par_err} !== '0) begin
      tests_failed++; $display("FAIL reset_hold got %h want 0", {dout, dout_vld, bit_cnt, overrun, par_err});
    end
    rst = 1'b1;
    @(negedge clk);
    dout_rdy = 1'b0;
    exp_q.push_back(expect_word(4'b1101, 1'b0));
    send_word(4'b1101, 1'b0);
    exp = exp_q.pop_front();
    tests_run++;
    if (dout !== exp || dout_vld !== 1'b1) begin
      tests_failed++; $display("FAIL reset_preword got %b/%b want %b/1", dout, dout_vld, exp);
    end
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);
    tests_run++;
    if (bit_cnt !== CNT_W'(2)) begin
      tests_failed++; $display("FAIL reset_partial_cnt got %0d want 2", bit_cnt);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({dout, dout_vld, bit_cnt, overrun, par_err} !== '0) begin
      tests_failed++; $display("FAIL reset_async got %h want 0", {dout, dout_vld, bit_cnt, overrun, par_err});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    dout_rdy = 1'b1;
    exp_q.push_back(expect_word(4'b0110, 1'b0));
    send_word(4'b0110, 1'b0);
    exp = exp_q.pop_front();
    tests_run++;
    if (dout !== exp || dout_vld !== 1'b1) begin
      tests_failed++; $display("FAIL reset_discard got %b/%b want %b/1", dout, dout_vld, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_msb_first();
    logic [0:3] bits;
    logic [3:0] exp;
    bits = 4'b1011;
    dout_rdy = 1'b1;
    exp_q.push_back(expect_word(bits, 1'b0));
    for (int i = 0; i < 4; i++) begin
      bit_in(bits[i], 1'b0);
      if (i < 3) begin
        tests_run++;
        if (bit_cnt !== CNT_W'(i + 1) || dout_vld !== 1'b0) begin
          tests_failed++; $display("FAIL msb_progress%0d got cnt=%0d vld=%b want cnt=%0d vld=0", i, bit_cnt, dout_vld, i + 1);
        end
      end
    end
`ifdef USR_DESER_PARITY_EN
    bit_in(^bits, 1'b0);
`endif
    exp = exp_q.pop_front();
    tests_run++;
    if (dout !== exp || dout_vld !== 1'b1 || bit_cnt !== '0) begin
      tests_failed++; $display("FAIL msb_word got %b vld=%b cnt=%0d want %b vld=1 cnt=0", dout, dout_vld, bit_cnt, exp);
    end
    @(negedge clk);
    tests_run++;
    if (dout_vld !== 1'b0 || dout !== exp) begin
      tests_failed++; $display("FAIL msb_vld_pulse got vld=%b dout=%b want vld=0 dout=%b", dout_vld, dout, exp);
    end
  endtask

  task automatic test_lsb_gaps();
    logic [0:3] bits;
    logic [3:0] exp;
    bits = 4'b1101;
    dout_rdy = 1'b1;
    exp_q.push_back(expect_word(bits, 1'b1));
    for (int i = 0; i < FRAME; i++) begin
      if (i < 4) bit_in(bits[i], 1'b1);
      else       bit_in(^bits, 1'b1);
      tests_run++;
      if (bit_cnt !== CNT_W'((i + 1) % FRAME)) begin
        tests_failed++; $display("FAIL lsb_cnt%0d got %0d want %0d", i, bit_cnt, (i + 1) % FRAME);
      end
      if (i == FRAME - 1) begin
        exp = exp_q.pop_front();
        tests_run++;
        if (dout !== exp || dout_vld !== 1'b1) begin
          tests_failed++; $display("FAIL lsb_word got %b/%b want %b/1", dout, dout_vld, exp);
        end
      end else begin
        repeat (2) @(negedge clk);
        tests_run++;
        if (bit_cnt !== CNT_W'(i + 1) || dout_vld !== 1'b0) begin
          tests_failed++; $display("FAIL lsb_gap_hold%0d got cnt=%0d vld=%b want cnt=%0d vld=0", i, bit_cnt, dout_vld, i + 1);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_overrun();
    logic [3:0] exp;
    dout_rdy = 1'b0;
    exp_q.push_back(expect_word(4'b1011, 1'b0));
    send_word(4'b1011, 1'b0);
    exp = exp_q.pop_front();
    tests_run++;
    if (dout !== exp || dout_vld !== 1'b1 || overrun !== 1'b0) begin
      tests_failed++; $display("FAIL ovr_first got %b vld=%b ovr=%b want %b vld=1 ovr=0", dout, dout_vld, overrun, exp);
    end
    send_word(4'b0110, 1'b0);
    tests_run++;
    if (dout !== exp || dout_vld !== 1'b1 || overrun !== 1'b1) begin
      tests_failed++; $display("FAIL ovr_drop got %b vld=%b ovr=%b want %b vld=1 ovr=1", dout, dout_vld, overrun, exp);
    end
    dout_rdy = 1'b1;
    @(negedge clk);
    tests_run++;
    if (dout_vld !== 1'b0 || overrun !== 1'b1) begin
      tests_failed++; $display("FAIL ovr_consume got vld=%b ovr=%b want vld=0 ovr=1", dout_vld, overrun);
    end
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    clr = 1'b1; sin = 1'b1; sin_vld = 1'b1;
    @(negedge clk);
    clr = 1'b0; sin_vld = 1'b0;
    tests_run++;
    if (overrun !== 1'b0 || bit_cnt !== '0 || dout_vld !== 1'b0 || dout !== exp) begin
      tests_failed++; $display("FAIL ovr_clr got ovr=%b cnt=%0d vld=%b dout=%b want 0/0/0/%b", overrun, bit_cnt, dout_vld, dout, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:3] a_bits;
    logic [0:3] b_bits;
    logic [3:0] exp;
    a_bits = 4'b1010;
    b_bits = 4'b1010;
    dout_rdy = 1'b0;
    exp_q.push_back(expect_word(a_bits, 1'b0));
    for (int i = 0; i < 4; i++) bit_in(a_bits[i], (i == 0) ? 1'b0 : 1'b1);
`ifdef USR_DESER_PARITY_EN
    bit_in(^a_bits, 1'b1);
`endif
    exp = exp_q.pop_front();
    tests_run++;
    if (dout !== exp || dout_vld !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_first got %b/%b want %b/1", dout, dout_vld, exp);
    end
    exp_q.push_back(expect_word(b_bits, 1'b1));
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && !PAR) dout_rdy = 1'b1;
      bit_in(b_bits[i], (i == 0) ? 1'b1 : 1'b0);
    end
`ifdef USR_DESER_PARITY_EN
    dout_rdy = 1'b1;
    bit_in(^b_bits, 1'b0);
`endif
    exp = exp_q.pop_front();
    tests_run++;
    if (dout !== exp || dout_vld !== 1'b1 || overrun !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_boundary got %b vld=%b ovr=%b want %b vld=1 ovr=0", dout, dout_vld, overrun, exp);
    end
    @(negedge clk);
    tests_run++;
    if (dout_vld !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_drain got vld=%b want 0", dout_vld);
    end
  endtask

`ifdef USR_DESER_PARITY_EN
  task automatic test_parity();
    logic [3:0] exp;
    dout_rdy = 1'b1;
    exp_q.push_back(expect_word(4'b1011, 1'b0));
    for (int i = 0; i < 4; i++) bit_in(exp_q[0][3-i], 1'b0);
    bit_in(1'b1, 1'b0);
    exp = exp_q.pop_front();
    tests_run++;
    if (dout !== exp || par_err !== 1'b0) begin
      tests_failed++; $display("FAIL par_good got %b perr=%b want %b perr=0", dout, par_err, exp);
    end
    @(negedge clk);
    exp_q.push_back(expect_word(4'b1011, 1'b0));
    for (int i = 0; i < 4; i++) bit_in(exp_q[0][3-i], 1'b0);
    bit_in(1'b0, 1'b0);
    exp = exp_q.pop_front();
    tests_run++;
    if (dout !== exp || par_err !== 1'b1 || dout_vld !== 1'b1) begin
      tests_failed++; $display("FAIL par_bad got %b perr=%b vld=%b want %b perr=1 vld=1", dout, par_err, dout_vld, exp);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_gaps();
    test_overrun();
    test_back_to_back();
`ifdef USR_DESER_PARITY_EN
    test_parity();
`endif
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/usr_deser.md
Name: usr_deser

Overview:
- Receive-side partner of the universal shift register.
- Accepts a serial bit stream, one bit per qualified clock, in either shift direction, and reassembles it into WIDTH-bit parallel words.
- Completed words go to a holding register with a valid/ready handshake, for downstream logic or a display.
- Sits at the far end of a serial link driven by the shift-register block in serial-out mode.

Parameters:
- WIDTH, 4: word length in bits; legal range 2..16.
- CNT_W, 4: bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- sin  input  1  serial data bit.
- sin_vld  input  1  sin is sampled on this edge only when high.
- dir  input  1  0 = MSB-first (left-shift stream), 1 = LSB-first (right-shift stream).
- clr  input  1  synchronous flush of the partial word and flags.
- dout_rdy  input  1  consumer accepts dout this cycle.
- dout  output  WIDTH  assembled word.
- dout_vld  output  1  dout holds an unconsumed word.
- bit_cnt  output  CNT_W  bits received in the current partial word.
- overrun  output  1  sticky: a completed word was dropped.
- par_err  output  1  parity error flag for dout (see Optional Feature).

Behaviour:
- Reset (rst low, async): shift register, dout, bit_cnt, dout_vld, overrun and par_err all clear to 0; FSM goes to IDLE.
- FSM states:
  - IDLE: bit_cnt = 0.
  - SHIFT: partial word in progress.
- Transitions:
  - IDLE -> SHIFT on the first sampled bit.
  - SHIFT -> IDLE on the edge that samples the last bit of a frame.
- Direction: dir is latched on the first bit of each word. Changes to dir mid-word are ignored until the next word.
- Bit placement:
  - MSB-first: sreg <= {sreg[WIDTH-2:0], sin}.
  - LSB-first: sreg <= {sin, sreg[WIDTH-1:1]}.
- sin_vld low: everything holds. Gaps between bits are legal and unbounded.
- bit_cnt increments per sampled bit and wraps to 0 at frame end.
- Latency: on the edge sampling the final bit, the complete word (including that bit) loads into dout. dout_vld is high immediately after that same edge, so there are zero extra cycles.
- Handshake: a word is consumed on any edge where dout_vld && dout_rdy. dout_vld then falls unless a new word loads on that same edge.
- Simultaneous completion and consume: the new word loads, dout_vld stays 1, and no overrun is raised.
- Completion while dout_vld && !dout_rdy: the new word is dropped, dout is unchanged, overrun is set to 1 and stays set until clr or reset.
- clr (sync, has priority over sin_vld on the same edge):
  - sreg, bit_cnt, overrun, par_err and dout_vld clear to 0.
  - FSM goes to IDLE.
  - dout data value is retained.
- Reset mid-word: the partial word is discarded with no output.

Optional Feature:
- Macro: USR_DESER_PARITY_EN.
- Defined:
  - A frame is WIDTH data bits followed by one even-parity bit.
  - bit_cnt counts 0..WIDTH; the parity bit is not shifted into sreg.
  - par_err loads with dout as (^data) ^ parity_bit.
  - par_err is valid while dout_vld is high.
- Undefined:
  - A frame is WIDTH bits.
  - par_err is tied to 0.
  - The port remains present.

Decomposition:
- Shared package usr_pkg holds:
  - DIR_MSB_FIRST = 1'b0, DIR_LSB_FIRST = 1'b1 (shared with the shift-register transmitter).
  - The FSM state encoding (IDLE = 1'b0, SHIFT = 1'b1).
- One sub-module: usr_deser_out, the holding register with the valid/ready/overrun logic. It is reusable by other stream sinks.

Test Plan:
- Reset check: reset asserted async mid-cycle -> all outputs 0 within the same cycle.
- MSB-first word: dir=0, bits 1,0,1,1 on consecutive sin_vld cycles, dout_rdy=1 -> dout=4'b1011, dout_vld high for exactly 1 cycle after the 4th edge.
- LSB-first word with gaps: dir=1, bits 1,1,0,1 with 2 idle cycles between bits -> dout=4'b1011; bit_cnt shows 1,2,3,0.
- Overrun: dout_rdy=0, send 4'b1011 then 4'b0110 -> dout stays 4'b1011, overrun=1. Then dout_rdy=1 -> dout_vld drops; clr clears overrun.
- Back-to-back stream: continuous sin_vld, dout_rdy=1, words 4'hA then 4'h5 -> dout_vld stays high across the boundary with no overrun. Also toggle dir mid-word -> no effect until the next word.
- USR_DESER_PARITY_EN defined:
  - Frame 1,0,1,1,p=1 -> dout=4'b1011, par_err=0.
  - Frame 1,0,1,1,p=0 -> par_err=1.
